mem_read_client_adapter: RTL and testbench
==========================================

// Module: mem_read_client_adapter
// PURPOSE
//  Per-client read front end for one read port of the multibank memory.
//  Buffers client read requests in a request FIFO and issues them to the port (addr/avalid/aready).
//  Collects in-order read data (dvalid/data) into a response FIFO and returns it to the client with valid/ready.
//  Credit limit on issue: the response FIFO can never overflow, whatever the bank-conflict stalls or memory latency.
// PARAMETERS
//  DATA_WIDTH  32  read data width
//  ADDR_WIDTH  4   global word address width, same as the memory
//  REQ_DEPTH   4   request FIFO entries; power of two, >=2
//  RSP_DEPTH   4   response FIFO entries = max requests in flight + buffered; power of two, >=2
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-low
//  req_addr      in   ADDR_WIDTH  client read address
//  req_valid     in   1           client request valid
//  req_ready     out  1           request FIFO not full
//  rsp_data      out  DATA_WIDTH  head of response FIFO
//  rsp_valid     out  1           response FIFO not empty
//  rsp_ready     in   1           client takes response
//  mem_addr      out  ADDR_WIDTH  to memory r_addr[k]
//  mem_avalid    out  1           to memory r_avalid[k]
//  mem_aready    in   1           from memory r_aready[k]
//  mem_dvalid    in   1           from memory r_dvalid[k]
//  mem_data      in   DATA_WIDTH  from memory r_data[k]
//  outstanding   out  $clog2(RSP_DEPTH+1)  requests issued, data not yet returned
//  err_unexp     out  1           sticky: dvalid seen with outstanding==0
// BEHAVIOUR
//  Reset (rst=0, async):
//   - Pointers, counts and outstanding go to 0; err_unexp=0.
//   - rsp_valid=0, mem_avalid=0, req_ready=1.
//   - Everything in flight is dropped; no partial state is kept.
//  Request side:
//   - Push when req_valid && req_ready.
//   - req_ready = !req_full only. No push-on-pop bypass: a full FIFO refuses even in a cycle it pops.
//  Issue:
//   - credit_ok = (outstanding + rsp_count) < RSP_DEPTH.
//   - mem_avalid = !req_empty && credit_ok; mem_addr = request FIFO head (registered storage).
//   - Issue = mem_avalid && mem_aready: pop request, outstanding += 1.
//   - While mem_avalid=1 and mem_aready=0, mem_addr holds stable and mem_avalid stays 1 (no retraction).
//   - A request pushed in cycle T can issue no earlier than T+1.
//  Return:
//   - The memory returns data in issue order. The adapter does no reordering or tagging.
//   - mem_dvalid && outstanding>0: push mem_data into response FIFO, outstanding -= 1.
//   - Issue and return in the same cycle leave outstanding unchanged.
//   - mem_dvalid with outstanding==0: data discarded, err_unexp set until reset. Covers stale data after a mid-op reset.
//   - rsp_valid = !rsp_empty. Pop on rsp_valid && rsp_ready. Data returned in cycle R is visible at R+1.
//   - Response push and pop in the same cycle are both allowed; rsp_count is unchanged.
//  Widths and wrap:
//   - Pointers are $clog2(DEPTH) bits and wrap naturally.
//   - Counts are $clog2(DEPTH+1) bits and never exceed DEPTH.
//   - The credit rule guarantees outstanding + rsp_count <= RSP_DEPTH; assert this.
//  Throughput: with mem_aready=1, 1-cycle memory latency and rsp_ready=1, one request per clock is sustained.
// TESTING
//  1. Reset, push addr 3,7,9 back-to-back, aready=1, latency 1 -> mem_addr 3,7,9 on consecutive cycles; rsp_data returns in that order.
//  2. aready=0 for 5 cycles with 6 pushes (REQ_DEPTH=4) -> req_ready drops after 4th push; mem_addr held at 1st addr; no loss after aready=1.
//  3. rsp_ready=0, aready=1, 6 requests -> exactly 4 issued (credit); mem_avalid=0 with 2 still queued; rsp_ready=1 -> remaining 2 issue.
//  4. Issue and dvalid in the same cycle at outstanding=2 -> outstanding stays 2; response FIFO order preserved.
//  5. Assert rst mid-burst with 3 outstanding, then dvalid pulses -> all outputs at reset values; first stray dvalid sets err_unexp=1; rsp_valid stays 0.
//  6. Random req/aready/rsp_ready/latency 1..4, 10k cycles -> scoreboard matches data per address; no overflow assertion fires.

Source files
------------

// File: rtl/mem_read_client_adapter.sv
// rtl/mem_read_client_adapter.sv - per-client read front end: request FIFO, credit-limited issue, response FIFO
module mem_read_client_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int REQ_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic                           req_valid,
  output logic                           req_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_avalid,
  input  logic                           mem_aready,
  input  logic                           mem_dvalid,
  input  logic [DATA_WIDTH-1:0]          mem_data,
  output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding,
  output logic                           err_unexp
);

  localparam int QPW = $clog2(REQ_DEPTH);
  localparam int QCW = $clog2(REQ_DEPTH + 1);
  localparam int SPW = $clog2(RSP_DEPTH);
  localparam int SCW = $clog2(RSP_DEPTH + 1);
  localparam logic [QCW-1:0] REQ_FULL_CNT = QCW'(REQ_DEPTH);
  localparam logic [SCW-1:0] RSP_FULL_CNT = SCW'(RSP_DEPTH);
  localparam logic [SCW:0]   CREDIT_LIM   = (SCW+1)'(RSP_DEPTH);

  logic [ADDR_WIDTH-1:0] req_mem [REQ_DEPTH];
  logic [QPW-1:0]        req_wr_ptr;
  logic [QPW-1:0]        req_rd_ptr;
  logic [QCW-1:0]        req_count;
  logic                  req_full;
  logic                  req_empty;
  logic                  req_push;
  logic                  req_pop;

  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [SPW-1:0]        rsp_wr_ptr;
  logic [SPW-1:0]        rsp_rd_ptr;
  logic [SCW-1:0]        rsp_count;
  logic                  rsp_full;
  logic                  rsp_empty;
  logic                  rsp_push;
  logic                  rsp_pop;

  logic [SCW:0]          credit_sum;
  logic                  credit_ok;
  logic                  issue;
  logic                  ret_ok;
  logic                  ret_stray;

  assign req_full  = (req_count == REQ_FULL_CNT);
  assign req_empty = (req_count == '0);
  assign req_ready = !req_full;
  assign req_push  = req_valid && req_ready;

  // Entries already in the response FIFO plus those still in flight must fit in it.
  assign credit_sum = {1'b0, outstanding} + {1'b0, rsp_count};
  assign credit_ok  = (credit_sum < CREDIT_LIM);

  assign mem_avalid = !req_empty && credit_ok;
  assign mem_addr   = req_mem[req_rd_ptr];
  assign issue      = mem_avalid && mem_aready;
  assign req_pop    = issue;

  assign ret_ok    = mem_dvalid && (outstanding != '0);
  assign ret_stray = mem_dvalid && (outstanding == '0);

  assign rsp_full  = (rsp_count == RSP_FULL_CNT);
  assign rsp_empty = (rsp_count == '0);
  assign rsp_valid = !rsp_empty;
  assign rsp_push  = ret_ok;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_mem[rsp_rd_ptr];

  always_ff @(posedge clk) begin
    if (req_push) begin
      req_mem[req_wr_ptr] <= req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_count  <= '0;
    end else begin
      if (req_push) begin
        req_wr_ptr <= req_wr_ptr + 1'b1;
      end
      if (req_pop) begin
        req_rd_ptr <= req_rd_ptr + 1'b1;
      end
      case ({req_push, req_pop})
        2'b10:   req_count <= req_count + 1'b1;
        2'b01:   req_count <= req_count - 1'b1;
        default: req_count <= req_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      err_unexp   <= 1'b0;
    end else begin
      case ({issue, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (ret_stray) begin
        err_unexp <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) begin
        rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      end
      if (rsp_pop) begin
        rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      end
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    credit_sum <= CREDIT_LIM);

  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_push && rsp_full && !rsp_pop));

endmodule

// File: tb/tb_mem_read_client_adapter.sv
// tb/tb_mem_read_client_adapter.sv - scoreboard bench for mem_read_client_adapter
module tb_mem_read_client_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  mem_addr;
  logic        mem_avalid;
  logic        mem_aready = 1'b0;
  logic        mem_dvalid = 1'b0;
  logic [31:0] mem_data = '0;
  logic [2:0]  outstanding;
  logic        err_unexp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_issue = 0;
  int lat = 1;
  bit model_en = 1'b1;

  logic [3:0]  exp_addr[$];
  logic [31:0] exp_rsp[$];

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;
  pend_t pend[$];
  int    last_due = 0;

  mem_read_client_adapter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .REQ_DEPTH(4), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .mem_addr(mem_addr), .mem_avalid(mem_avalid), .mem_aready(mem_aready),
    .mem_dvalid(mem_dvalid), .mem_data(mem_data),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: word at address a is 0xABCD000a.
  function automatic logic [31:0] mem_word(input logic [3:0] a);
    return 32'hABCD_0000 | {28'h0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [3:0] a);
    bit ok;
    ok = 1'b0;
    req_addr  = a;
    req_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accept", 32'(ok), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (exp_rsp.size() == 0 && outstanding == 3'd0 && !rsp_valid && !mem_avalid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 32'(done), 32'd1);
  endtask

  // Memory port model: in-order returns, each issue returned after lat cycles.
  initial begin
    pend_t p;
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
          mem_dvalid = 1'b1;
          mem_data   = pend[0].d;
          p = pend.pop_front();
        end else begin
          mem_dvalid = 1'b0;
          mem_data   = '0;
        end
      end
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        last_due = 0;
      end else if (mem_avalid && mem_aready) begin
        p.due = cyc + 1 + lat;
        if (p.due <= last_due) p.due = last_due + 1;
        p.d = mem_word(mem_addr);
        last_due = p.due;
        pend.push_back(p);
      end
    end
  end

  // Monitor: compares issued addresses and returned responses against the scoreboard.
  bit         prev_stall = 1'b0;
  logic [3:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        check("hold_avalid", 32'(mem_avalid), 32'd1);
        check("hold_addr", 32'(mem_addr), 32'(prev_addr));
      end
      if (mem_avalid && mem_aready) begin
        n_issue++;
        if (exp_addr.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
        else check("issue_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", rsp_data, 32'hxxxx_xxxx);
        else check("rsp_data", rsp_data, exp_rsp.pop_front());
      end
      if (req_valid && req_ready) begin
        exp_addr.push_back(req_addr);
        exp_rsp.push_back(mem_word(req_addr));
      end
      check("outstanding_bound", 32'(outstanding <= 3'd4), 32'd1);
      prev_stall = mem_avalid && !mem_aready;
      prev_addr  = mem_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_avalid", 32'(mem_avalid), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err_unexp", 32'(err_unexp), 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // 1: three back-to-back requests, latency 1
    lat = 1; mem_aready = 1'b1; rsp_ready = 1'b1;
    push_req(4'd3);
    check("t1_avalid", 32'(mem_avalid), 32'd1);
    check("t1_addr0", 32'(mem_addr), 32'd3);
    push_req(4'd7);
    check("t1_addr1", 32'(mem_addr), 32'd7);
    push_req(4'd9);
    check("t1_addr2", 32'(mem_addr), 32'd9);
    drain();

    // 2: memory stalls for 5 cycles while the client pushes 6 requests
    mem_aready = 1'b0;
    push_req(4'd1);
    push_req(4'd2);
    push_req(4'd3);
    push_req(4'd4);
    check("t2_full", 32'(req_ready), 32'd0);
    check("t2_hold_addr", 32'(mem_addr), 32'd1);
    check("t2_hold_avalid", 32'(mem_avalid), 32'd1);
    req_addr = 4'd5; req_valid = 1'b1;
    tick();
    check("t2_still_full", 32'(req_ready), 32'd0);
    mem_aready = 1'b1;
    push_req(4'd5);
    push_req(4'd6);
    drain();

    // 3: client not draining responses, credit caps issue at 4
    rsp_ready = 1'b0; base = n_issue;
    for (int i = 10; i < 16; i++) push_req(4'(i));
    repeat (6) tick();
    check("t3_issued4", 32'(n_issue - base), 32'd4);
    check("t3_avalid_off", 32'(mem_avalid), 32'd0);
    check("t3_outstanding", 32'(outstanding), 32'd0);
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    drain();
    check("t3_issued6", 32'(n_issue - base), 32'd6);

    // 4: issue and return in the same cycle at outstanding=2
    lat = 2;
    push_req(4'd2);
    push_req(4'd4);
    push_req(4'd6);
    check("t4_out_p3", 32'(outstanding), 32'd2);
    push_req(4'd8);
    check("t4_out_p4", 32'(outstanding), 32'd2);
    tick();
    check("t4_out_p5", 32'(outstanding), 32'd2);
    drain();

    // 5: reset with 3 outstanding, then stray returns
    lat = 4;
    push_req(4'd1);
    push_req(4'd2);
    push_req(4'd3);
    tick();
    check("t5_out3", 32'(outstanding), 32'd3);
    model_en = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_avalid", 32'(mem_avalid), 32'd0);
    check("t5_outstanding", 32'(outstanding), 32'd0);
    check("t5_err0", 32'(err_unexp), 32'd0);
    exp_addr.delete();
    exp_rsp.delete();
    mem_dvalid = 1'b0;
    tick();
    rst = 1'b1;
    mem_dvalid = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_dvalid = 1'b0;
    check("t5_err1", 32'(err_unexp), 32'd1);
    check("t5_rsp_valid_stray", 32'(rsp_valid), 32'd0);
    check("t5_out_stray", 32'(outstanding), 32'd0);
    mem_dvalid = 1'b1;
    tick();
    mem_dvalid = 1'b0;
    tick();
    check("t5_err_sticky", 32'(err_unexp), 32'd1);
    check("t5_rsp_valid_stray2", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_err_cleared", 32'(err_unexp), 32'd0);
    tick();
    rst = 1'b1;
    model_en = 1'b1;

    // 6: random traffic
    for (int i = 0; i < 10000; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = 4'($urandom_range(0, 15));
      mem_aready = ($urandom_range(0, 3) != 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      lat        = int'($urandom_range(1, 4));
      tick();
    end
    req_valid = 1'b0; mem_aready = 1'b1; rsp_ready = 1'b1;
    drain();
    check("t6_no_err", 32'(err_unexp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
